// File: rtl/chamber_timer_pkg.sv
// Shared types and constants for the airlock seconds timer.
// Holds the state encoding, target-select codes and default durations.
package chamber_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_SHORT = 2'd0;
    localparam logic [1:0] SEL_MED   = 2'd1;
    localparam logic [1:0] SEL_LONG  = 2'd2;

    localparam int DEF_T_A = 5;
    localparam int DEF_T_B = 7;
    localparam int DEF_T_C = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick per counted second.
// The tick fires combinationally in the last cycle of each period.
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 781250
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chamber_timer.sv
// Airlock seconds timer: start/clear handshake, selectable target,
// one-hot threshold flags and a single-cycle done pulse.
module chamber_timer
    import chamber_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 781250,
    parameter int SEC_W         = 4,
    parameter int T_A           = DEF_T_A,
    parameter int T_B           = DEF_T_B,
    parameter int T_C           = DEF_T_C
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [1:0]       sel,
    output logic [SEC_W-1:0] seconds,
    output logic [2:0]       thresh,
    output logic             busy,
    output logic             done
);

    if (TICKS_PER_SEC < 2) begin : g_bad_ticks
        $error("chamber_timer: TICKS_PER_SEC must be >= 2");
    end
    if (T_A < 1 || T_A >= 2**SEC_W || T_B < 1 || T_B >= 2**SEC_W ||
        T_C < 1 || T_C >= 2**SEC_W) begin : g_bad_target
        $error("chamber_timer: targets must be nonzero and fit SEC_W");
    end

    localparam logic [SEC_W-1:0] TA = SEC_W'(T_A);
    localparam logic [SEC_W-1:0] TB = SEC_W'(T_B);
    localparam logic [SEC_W-1:0] TC = SEC_W'(T_C);
    localparam logic [SEC_W-1:0] SEC_MAX = '1;

    state_e           state_q;
    logic [SEC_W-1:0] sec_q;
    logic [SEC_W-1:0] tgt_q;
    logic [SEC_W-1:0] tgt_d;
    logic [SEC_W-1:0] sec_d;
    logic             busy_q;
    logic             done_q;
    logic             accept;
    logic             tick;

    // A start in RUN is ignored, so only IDLE/DONE accept it.
    assign accept = start && (state_q != RUN);

    always_comb begin
        tgt_d = TC;
        unique case (sel)
            SEL_SHORT: tgt_d = TA;
            SEL_MED:   tgt_d = TB;
            default:   tgt_d = TC;
        endcase
    end

    assign sec_d = (sec_q == SEC_MAX) ? sec_q : sec_q + 1'b1;

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_presc (
        .clock(clock),
        .reset(reset),
        .clr  (accept | clear),
        .en   (state_q == RUN),
        .tick (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sec_q   <= '0;
            tgt_q   <= TC;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            sec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        tgt_q   <= tgt_d;
                        sec_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        sec_q <= sec_d;
                        if (sec_d == tgt_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seconds = sec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign thresh  = {sec_q == TC, sec_q == TB, sec_q == TA};

endmodule

// File: tb/tb_chamber_timer.sv
// Self-checking bench for chamber_timer with a 4-cycle second.
// A cycle model pushes expected outputs; a monitor pops and compares.
module tb_chamber_timer;

    localparam int TPS = 4;

    logic       clock;
    logic       reset;
    logic       start;
    logic       clear;
    logic [1:0] sel;
    logic [3:0] seconds;
    logic [2:0] thresh;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] sec;
        logic [2:0] th;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];

    // reference model state: 0 idle, 1 run, 2 done
    int m_st  = 0;
    int m_cyc = 0;
    int m_tgt = 8;
    bit m_done = 0;

    chamber_timer #(
        .TICKS_PER_SEC(TPS),
        .SEC_W(4),
        .T_A(5),
        .T_B(7),
        .T_C(8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .clear  (clear),
        .sel    (sel),
        .seconds(seconds),
        .thresh (thresh),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int sel_tgt(input logic [1:0] s);
        if (s == 2'd0) return 5;
        if (s == 2'd1) return 7;
        return 8;
    endfunction

    task automatic drive(input logic st, input logic cl,
                         input logic rs, input logic [1:0] s);
        exp_t e;
        int   sv;
        @(negedge clock);
        start = st;
        clear = cl;
        reset = rs;
        sel   = s;
        m_done = 0;
        if (rs) begin
            m_st = 0; m_cyc = 0; m_tgt = 8;
        end else if (cl) begin
            m_st = 0; m_cyc = 0;
        end else if (st && m_st != 1) begin
            m_st = 1; m_cyc = 0; m_tgt = sel_tgt(s);
        end else if (m_st == 1) begin
            m_cyc++;
            if (m_cyc / TPS == m_tgt) begin
                m_st = 2;
                m_done = 1;
            end
        end
        sv = (m_st == 1) ? m_cyc / TPS : (m_st == 2) ? m_tgt : 0;
        e.sec  = 4'(sv);
        e.th   = {sv == 8, sv == 7, sv == 5};
        e.busy = (m_st == 1);
        e.done = m_done;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({seconds, thresh, busy, done} !== e)
                $display("FAIL sb t=%0t got sec=%0d th=%b busy=%b done=%b exp sec=%0d th=%b busy=%b done=%b",
                         $time, seconds, thresh, busy, done,
                         e.sec, e.th, e.busy, e.done);
            if ({seconds, thresh, busy, done} !== e) errors++;
        end
    end

    task automatic wait_done(output int n, input int lim);
        n = 0;
        do begin
            drive(0, 0, 0, 2'd0);
            n++;
        end while (!done && n < lim);
    endtask

    task automatic test_reset();
        drive(0, 0, 1, 2'd0);
        drive(0, 0, 1, 2'd0);
        checks++;
        if ({seconds, thresh, busy, done} !== 9'd0) begin
            errors++;
            $display("FAIL reset_vals got %b exp 0", {seconds, thresh, busy, done});
        end
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 2'd0);
    endtask

    task automatic test_short();
        int n;
        drive(1, 0, 0, 2'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL short_busy got %b exp 1", busy);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 2'd0);
        checks++;
        if (seconds !== 4'd1) begin
            errors++;
            $display("FAIL short_sec1 got %0d exp 1", seconds);
        end
        wait_done(n, 40);
        n += 4;
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL short_lat got %0d exp 20", n);
        end
        checks++;
        if (thresh !== 3'b001 || seconds !== 4'd5) begin
            errors++;
            $display("FAIL short_at_done got th=%b sec=%0d exp 001/5", thresh, seconds);
        end
        drive(0, 0, 0, 2'd0);
        checks++;
        if (done !== 1'b0 || seconds !== 4'd5) begin
            errors++;
            $display("FAIL short_hold got done=%b sec=%0d exp 0/5", done, seconds);
        end
    endtask

    task automatic test_long();
        int n;
        logic [2:0] th5;
        logic [2:0] th7;
        th5 = 'x;
        th7 = 'x;
        drive(1, 0, 0, 2'd2);
        n = 0;
        do begin
            drive(0, 0, 0, 2'd0);
            n++;
            if (seconds == 4'd5) th5 = thresh;
            if (seconds == 4'd7) th7 = thresh;
        end while (!done && n < 60);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL long_lat got %0d exp 32", n);
        end
        checks++;
        if (th5 !== 3'b001 || th7 !== 3'b010 || thresh !== 3'b100) begin
            errors++;
            $display("FAIL long_thresh got %b %b %b exp 001 010 100", th5, th7, thresh);
        end
    endtask

    task automatic test_clear();
        int n;
        bit saw_done;
        drive(1, 0, 0, 2'd1);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 2'd0);
        checks++;
        if (seconds !== 4'd3) begin
            errors++;
            $display("FAIL clr_pre got %0d exp 3", seconds);
        end
        drive(0, 1, 0, 2'd0);
        checks++;
        if (seconds !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clr_post got sec=%0d busy=%b done=%b exp 0/0/0", seconds, busy, done);
        end
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 2'd0);
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL clr_nodone got 1 exp 0");
        end
        drive(1, 0, 0, 2'd0);
        wait_done(n, 40);
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL clr_restart got %0d exp 20", n);
        end
    endtask

    task automatic test_start_clear();
        int n;
        drive(0, 1, 0, 2'd0);
        drive(1, 1, 0, 2'd0);
        checks++;
        if (seconds !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stclr got sec=%0d busy=%b exp 0/0", seconds, busy);
        end
        drive(1, 0, 0, 2'd1);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 2'd0);
        drive(1, 0, 0, 2'd0);
        wait_done(n, 40);
        n += 9;
        checks++;
        if (n !== 28 || seconds !== 4'd7) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d sec=%0d exp 28/7", n, seconds);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        drive(1, 0, 0, 2'd0);
        wait_done(n, 40);
        drive(0, 0, 0, 2'd0);
        drive(1, 0, 0, 2'd1);
        checks++;
        if (seconds !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart got sec=%0d busy=%b exp 0/1", seconds, busy);
        end
        wait_done(n, 40);
        checks++;
        if (n !== 28) begin
            errors++;
            $display("FAIL restart_lat got %0d exp 28", n);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 2'd2);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 2'd0);
        drive(1, 1, 1, 2'd1);
        checks++;
        if ({seconds, thresh, busy, done} !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid got %b exp 0", {seconds, thresh, busy, done});
        end
        drive(0, 0, 0, 2'd0);
        drive(0, 0, 0, 2'd0);
    endtask

    initial begin
        start = 0;
        clear = 0;
        reset = 1;
        sel   = 0;
        test_reset();
        test_short();
        test_long();
        test_clear();
        test_start_clear();
        test_back_to_back();
        test_reset_mid();
        @(posedge clock);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
